// File: rtl/match_pipe_pkg.sv
// Shared types and helpers for the delay-matching pipe.
// Imported by the control block and the pipe top.
package match_pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } mp_state_t;

  function automatic int mp_clamp(input int req, input int hi);
    int r;
    r = req;
    if (r < 1) r = 1;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/fixedp.sv
// Clock/reset bundle shared by the fixed-point operator datapaths.
// CROSSP_LAT is the cross-product latency that matched pipes adopt.
interface fixedp #(
  parameter int CROSSP_LAT = 3
);
  logic clk;
  logic reset_l;

  modport sink (
    input clk,
    input reset_l
  );
endinterface

// File: rtl/match_pipe_ctl.sv
// Delay switch FSM, in-flight counter and active/pending delay.
// Drains the active window before a new delay takes effect.
module match_pipe_ctl
  import match_pipe_pkg::*;
#(
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 1,
  parameter int DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          flush,
  input  logic          i_valid,
  input  logic          o_valid,
  input  logic [DW-1:0] delay_req,
  input  logic          delay_load,
  output logic          in_ready,
  output logic [DW-1:0] delay_cur,
  output logic [DW-1:0] inflight,
  output logic          clr_valid
);

  mp_state_t     state_q, state_d;
  logic [DW-1:0] pend_q, pend_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] req_c;
  logic          accept;
  logic          consume;

  assign req_c   = DW'(mp_clamp(int'(delay_req), MAX_DELAY));
  assign accept  = ce & i_valid & (state_q == RUN);
  assign consume = ce & o_valid;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    clr_valid = flush;
    if (accept && !consume) cnt_d = cnt_q + DW'(1);
    else if (!accept && consume) cnt_d = cnt_q - DW'(1);
    unique case (state_q)
      RUN: begin
        if (delay_load && req_c != cur_q) begin
          pend_d  = req_c;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (delay_load) pend_d = req_c;
        // window empty: switch, and drop stale entries past the old window
        if (cnt_q == '0) begin
          cur_d     = pend_d;
          state_d   = RUN;
          clr_valid = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (flush) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= DW'(DEFAULT_DELAY);
      cur_q   <= DW'(DEFAULT_DELAY);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign delay_cur = cur_q;
  assign inflight  = cnt_q;

endmodule

// File: rtl/match_pipe.sv
// Runtime-configurable valid-tagged delay pipe for side-band data.
// Stage array plus a registered-stage output mux at delay_cur-1.
module match_pipe
  import match_pipe_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int CHANNELS      = 1,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 1,
  parameter int DW            = $clog2(MAX_DELAY + 1)
) (
  fixedp.sink                      g,
  input  logic                     ce,
  input  logic                     flush,
  input  logic                     i_valid,
  input  logic [CHANNELS*WIDTH-1:0] i,
  output logic                     in_ready,
  input  logic [DW-1:0]            delay_req,
  input  logic                     delay_load,
  output logic                     o_valid,
  output logic [CHANNELS*WIDTH-1:0] o,
  output logic [DW-1:0]            delay_cur,
  output logic [DW-1:0]            inflight
);

  localparam int CW = CHANNELS * WIDTH;

  logic [MAX_DELAY-1:0] vld;
  logic [CW-1:0]        dat [MAX_DELAY];
  logic                 clr_valid;
  logic [DW-1:0]        sel;

  match_pipe_ctl #(
    .MAX_DELAY     (MAX_DELAY),
    .DEFAULT_DELAY (DEFAULT_DELAY),
    .DW            (DW)
  ) u_ctl (
    .clk        (g.clk),
    .rst_n      (g.reset_l),
    .ce         (ce),
    .flush      (flush),
    .i_valid    (i_valid),
    .o_valid    (o_valid),
    .delay_req  (delay_req),
    .delay_load (delay_load),
    .in_ready   (in_ready),
    .delay_cur  (delay_cur),
    .inflight   (inflight),
    .clr_valid  (clr_valid)
  );

  always_ff @(posedge g.clk) begin
    if (!g.reset_l) begin
      vld <= '0;
      for (int k = 0; k < MAX_DELAY; k++) dat[k] <= '0;
    end else begin
      if (clr_valid) vld <= '0;
      else if (ce) vld <= {vld[MAX_DELAY-2:0], i_valid & in_ready};
      if (ce) begin
        dat[0] <= i;
        for (int k = 1; k < MAX_DELAY; k++) dat[k] <= dat[k-1];
      end
    end
  end

  assign sel = delay_cur - DW'(1);

  always_comb begin
    o_valid = 1'b0;
    o       = '0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (sel == DW'(k)) begin
        o_valid = vld[k];
        o       = dat[k];
      end
    end
  end

endmodule

// File: doc/match_pipe.md
# match_pipe

Runtime-configurable, valid-tagged, multi-channel delay-matching pipe for the fixed-point math library. It carries side-band data alongside arithmetic units whose latency depends on the selected operation, such as cross product, dot product or add. The delay can be changed on the fly through a drain-then-switch handshake, and the whole pipe stalls on a shared clock enable. It sits next to the operator datapaths and takes its clock and reset from the `fixedp` bundle.

## Interface
Parameters:
- `WIDTH`, 1: bits per channel.
- `CHANNELS`, 1: parallel channels sharing one valid and one delay.
- `MAX_DELAY`, 16: stage count; the legal delay range is 1..MAX_DELAY.
- `DEFAULT_DELAY`, 1: `delay_cur` after reset.
- `DW`, $clog2(MAX_DELAY+1): width of the delay and count fields.

Ports:
- `g.clk`, input, 1: clock, delivered in `fixedp g`.
- `g.reset_l`, input, 1: reset, synchronous and active-low, delivered in `fixedp g`.
- `g`, interface, -: `fixedp` bundle.
- `ce`, input, 1: advance enable; the pipe shifts only when `ce`=1.
- `flush`, input, 1: synchronous clear of all in-flight data.
- `i_valid`, input, 1: input sample valid.
- `i`, input, CHANNELS*WIDTH: input data, channel k at [k*WIDTH +: WIDTH].
- `in_ready`, output, 1: high in RUN only.
- `delay_req`, input, DW: requested delay.
- `delay_load`, input, 1: one-cycle request strobe.
- `o_valid`, output, 1: output sample valid.
- `o`, output, CHANNELS*WIDTH: delayed data.
- `delay_cur`, output, DW: active delay.
- `inflight`, output, DW: count of valid samples in the active window.

## Operation
- Stage array `st[0..MAX_DELAY-1]`, each entry holding {valid, data}.
- When `ce`=1: `st[0]` <= {i_valid & in_ready, i} and `st[k]` <= `st[k-1]`. When `ce`=0, all stages hold.
- Outputs: `o` and `o_valid` are driven by `st[delay_cur-1]`, a register mux with no added register. A sample is consumed on any cycle where `ce` & `o_valid`.
- `inflight` update: +1 on an accepted sample (`ce` & `i_valid` & `in_ready`) and −1 on a consumed sample. When both occur in the same cycle, it is unchanged. It never exceeds `delay_cur`.
- The request value is clamped before use: 0→1, and anything above MAX_DELAY→MAX_DELAY.
- FSM states are RUN and DRAIN.
  - In RUN, `delay_load` with a clamped value different from `delay_cur` latches `pending` and moves to DRAIN. A load of the same value is a no-op.
  - In DRAIN, `in_ready`=0, so bubbles enter `st[0]` when `ce`=1 and `i_valid` is ignored. A new `delay_load` overwrites `pending` (last request wins).
  - In DRAIN, when `inflight`==0 at a clock edge: `delay_cur` <= `pending`, all stage valids are cleared (this discards stale entries beyond the old window), and the FSM returns to RUN. The switch happens even if `ce`=0.
- `flush`: all valids <= 0 and `inflight` <= 0, with the state held. A DRAIN in progress then completes on the following edge. If `flush` and `delay_load` arrive together, both take effect.
- Reset (`g.reset_l`=0 at an edge) returns every field to its reset value:
  - valids 0, data 0, `o` 0, `o_valid` 0;
  - `inflight` 0, `delay_cur` DEFAULT_DELAY, state RUN, `in_ready` 1, `pending` DEFAULT_DELAY.
- Reset overrides `flush`, `delay_load` and `ce`.

## Timing
- Latency is exactly `delay_cur` `ce`-qualified cycles from acceptance to `o_valid`. With `ce` held at 1, a sample accepted at edge t is visible on `o` after edge t+delay_cur-1.
- The worst-case switch costs `delay_cur` `ce`-cycles of drain plus one cycle. With an empty pipe, `in_ready` drops for exactly one cycle.
- `in_ready` and `delay_cur` are registered and change only at clock edges.

## Structure
- Package `match_pipe_pkg`:
  - state enum `mp_state_t` {RUN, DRAIN};
  - function `mp_clamp(req, max)`.
- Sub-module `match_pipe_ctl` holds the FSM, the `inflight` counter, and `pending`/`delay_cur`, and drives `in_ready` plus a `clr_valid` strobe.
- The top holds the stage array and the output mux.
- `crossp`-matched instances use DEFAULT_DELAY = g.CROSSP_LAT.

## Test plan
- **Fixed latency:** DEFAULT_DELAY=3, `ce`=1, sequential values 1,2,3… with `i_valid`=1 → `o` = 1 after edge t+2, one value per cycle, `inflight` steady at 3.
- **Stall:** as above, with `ce` low for 4 cycles mid-stream → `o`, `o_valid` and `inflight` frozen, no sample lost or duplicated, total latency 3+4 cycles.
- **Switch under load:** delay 3 with 3 in flight, load 7 → `in_ready`=0 until the last sample exits, then `delay_cur`=7. The next sample emerges 7 cycles after acceptance, with no stale `o_valid`.
- **Clamp / no-op / last-wins:** load 0 → `delay_cur`=1. Load 20 with MAX_DELAY=16 → 16. Load equal to current → `in_ready` never drops. Loads 5 then 9 during DRAIN → `delay_cur`=9.
- **Flush:** 4 in flight, `flush` pulse → `o_valid`=0 and `inflight`=0 next cycle. `flush`+`delay_load` together → switch completes one cycle later.
- **Reset mid-drain:** `g.reset_l`=0 during DRAIN → `delay_cur`=DEFAULT_DELAY, RUN, `in_ready`=1, all outputs 0.
